// File: rtl/tm_qm_assoc_rd_arb.sv
// Round-robin arbiter for the queue-association memory read port.
// Outstanding reads are tagged in an in-order FIFO so each ack returns to its issuer.
module tm_qm_assoc_rd_arb #(
    parameter int NUM_REQ    = 4,
    parameter int QID_NBITS  = 8,
    parameter int DATA_NBITS = 16,
    parameter int MAX_OUTST  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_rd,
    input  logic [NUM_REQ*QID_NBITS-1:0]   req_qid,
    output logic [NUM_REQ-1:0]             req_gnt,
    output logic [NUM_REQ-1:0]             rsp_ack,
    output logic [DATA_NBITS-1:0]          rsp_rdata,
    output logic                           queue_association_rd,
    output logic [QID_NBITS-1:0]           queue_association_raddr,
    input  logic                           queue_association_ack,
    input  logic [DATA_NBITS-1:0]          queue_association_rdata,
    output logic [$clog2(MAX_OUTST):0]     outst_cnt,
    output logic                           err_orphan_ack
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int AW    = $clog2(MAX_OUTST);
    localparam int CNT_W = AW + 1;

    logic [QID_NBITS-1:0]  qid_arr [NUM_REQ];
    logic [IDX_W-1:0]      tag_mem [MAX_OUTST];

    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      outst_cnt_q, outst_cnt_d;
    logic                  rd_q, rd_d;
    logic [QID_NBITS-1:0]  raddr_q, raddr_d;
    logic [NUM_REQ-1:0]    rsp_ack_q, rsp_ack_d;
    logic [DATA_NBITS-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  err_q, err_d;

    logic                  gnt_valid;
    logic [IDX_W-1:0]      winner;
    logic [IDX_W-1:0]      cand;
    logic                  push;
    logic                  pop;
    logic [IDX_W-1:0]      head;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_qid
        assign qid_arr[gi] = req_qid[gi*QID_NBITS +: QID_NBITS];
    end

    // Search starts one past the last winner; credits come from the registered count.
    always_comb begin
        gnt_valid = 1'b0;
        winner    = '0;
        cand      = '0;
        req_gnt   = '0;
        if (!rst && (outst_cnt_q < CNT_W'(MAX_OUTST))) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (!gnt_valid && req_rd[cand]) begin
                    gnt_valid = 1'b1;
                    winner    = cand;
                end
            end
        end
        if (gnt_valid) begin
            req_gnt[winner] = 1'b1;
        end
    end

    assign push = gnt_valid;
    assign pop  = queue_association_ack && (outst_cnt_q != '0);
    assign head = tag_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= winner;
        end
    end

    always_comb begin
        outst_cnt_d = outst_cnt_q;
        case ({push, pop})
            2'b10:   outst_cnt_d = outst_cnt_q + CNT_W'(1);
            2'b01:   outst_cnt_d = outst_cnt_q - CNT_W'(1);
            default: outst_cnt_d = outst_cnt_q;
        endcase
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        rr_ptr_d    = push ? winner : rr_ptr_q;
        rd_d        = push;
        raddr_d     = push ? qid_arr[winner] : raddr_q;
        rsp_ack_d   = '0;
        if (pop) begin
            rsp_ack_d[head] = 1'b1;
        end
        rsp_rdata_d = pop ? queue_association_rdata : rsp_rdata_q;
        err_d       = err_q | (queue_association_ack && (outst_cnt_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            outst_cnt_q <= '0;
            rd_q        <= 1'b0;
            raddr_q     <= '0;
            rsp_ack_q   <= '0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            outst_cnt_q <= outst_cnt_d;
            rd_q        <= rd_d;
            raddr_q     <= raddr_d;
            rsp_ack_q   <= rsp_ack_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    assign queue_association_rd    = rd_q;
    assign queue_association_raddr = raddr_q;
    assign rsp_ack                 = rsp_ack_q;
    assign rsp_rdata               = rsp_rdata_q;
    assign outst_cnt               = outst_cnt_q;
    assign err_orphan_ack          = err_q;

endmodule

// File: tb/tb_tm_qm_assoc_rd_arb.sv
// Directed bench: single read, fairness, credit limit, grant+ack overlap, orphan ack, reset mid-flight.
module tb_tm_qm_assoc_rd_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_rd = '0;
    logic [31:0] req_qid = '0;
    logic [3:0]  req_gnt;
    logic [3:0]  rsp_ack;
    logic [15:0] rsp_rdata;
    logic        mem_rd;
    logic [7:0]  mem_raddr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [2:0]  outst_cnt;
    logic        err_orphan_ack;

    int checks = 0;
    int errors = 0;

    tm_qm_assoc_rd_arb #(
        .NUM_REQ(4), .QID_NBITS(8), .DATA_NBITS(16), .MAX_OUTST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_rd(req_rd),
        .req_qid(req_qid),
        .req_gnt(req_gnt),
        .rsp_ack(rsp_ack),
        .rsp_rdata(rsp_rdata),
        .queue_association_rd(mem_rd),
        .queue_association_raddr(mem_raddr),
        .queue_association_ack(mem_ack),
        .queue_association_rdata(mem_rdata),
        .outst_cnt(outst_cnt),
        .err_orphan_ack(err_orphan_ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int exp_w [6] = '{0, 1, 2, 3, 0, 1};
    int cred_w [4] = '{2, 3, 0, 1};

    initial begin
        // Power-on reset
        #1 rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(req_gnt), 0);
        chk("rst_rd", 32'(mem_rd), 0);
        chk("rst_raddr", 32'(mem_raddr), 0);
        chk("rst_rsp_ack", 32'(rsp_ack), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        chk("rst_outst", 32'(outst_cnt), 0);
        chk("rst_err", 32'(err_orphan_ack), 0);
        tick; tick;
        rst = 1'b0;

        // Single request from requester 2
        tick;
        req_rd = 4'b0100; req_qid = {8'h00, 8'h15, 8'h00, 8'h00};
        #1;
        chk("single_gnt", 32'(req_gnt), 32'h4);
        chk("single_outst0", 32'(outst_cnt), 0);
        tick; req_rd = '0; #1;
        chk("single_rd", 32'(mem_rd), 1);
        chk("single_raddr", 32'(mem_raddr), 32'h15);
        chk("single_outst1", 32'(outst_cnt), 1);
        tick; #1;
        chk("single_rd_pulse", 32'(mem_rd), 0);
        chk("single_raddr_hold", 32'(mem_raddr), 32'h15);
        tick; mem_ack = 1'b1; mem_rdata = 16'h00A5; #1;
        tick; mem_ack = 1'b0; #1;
        chk("single_rsp_ack", 32'(rsp_ack), 32'h4);
        chk("single_rsp_rdata", 32'(rsp_rdata), 32'hA5);
        chk("single_outst2", 32'(outst_cnt), 0);
        tick; #1;
        chk("single_rsp_pulse", 32'(rsp_ack), 0);
        chk("single_rdata_hold", 32'(rsp_rdata), 32'hA5);

        // Fairness: reset so requester 0 wins first, all four held high
        tick; rst = 1'b1; tick; rst = 1'b0;
        req_qid = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 9; k++) begin
            tick;
            req_rd    = (k < 6) ? 4'hF : 4'h0;
            mem_ack   = (k >= 2 && k <= 7);
            mem_rdata = (k >= 2 && k <= 7) ? (16'hA010 + 16'(exp_w[k-2])) : 16'h0;
            #1;
            if (k < 6) chk($sformatf("fair_gnt%0d", k), 32'(req_gnt), 32'(1) << exp_w[k]);
            else       chk($sformatf("fair_gnt%0d", k), 32'(req_gnt), 0);
            if (k >= 1 && k <= 6) begin
                chk($sformatf("fair_rd%0d", k), 32'(mem_rd), 1);
                chk($sformatf("fair_raddr%0d", k), 32'(mem_raddr), 32'h10 + 32'(exp_w[k-1]));
            end
            if (k >= 3) begin
                chk($sformatf("fair_rsp%0d", k), 32'(rsp_ack), 32'(1) << exp_w[k-3]);
                chk($sformatf("fair_rdata%0d", k), 32'(rsp_rdata), 32'hA010 + 32'(exp_w[k-3]));
            end
        end
        tick; mem_ack = 1'b0; #1;
        chk("fair_outst_end", 32'(outst_cnt), 0);

        // Credit limit: acks withheld, rr_ptr currently 1
        for (int k = 0; k < 4; k++) begin
            tick; req_rd = 4'hF; #1;
            chk($sformatf("cred_gnt%0d", k), 32'(req_gnt), 32'(1) << cred_w[k]);
        end
        tick; #1;
        chk("cred_full_gnt", 32'(req_gnt), 0);
        chk("cred_full_outst", 32'(outst_cnt), 4);
        tick; mem_ack = 1'b1; mem_rdata = 16'hD000; #1;
        chk("cred_ack_no_gnt", 32'(req_gnt), 0);
        tick; mem_ack = 1'b0; #1;
        chk("cred_resume_gnt", 32'(req_gnt), 32'h4);
        chk("cred_outst3", 32'(outst_cnt), 3);
        chk("cred_rsp", 32'(rsp_ack), 32'h4);
        chk("cred_rdata", 32'(rsp_rdata), 32'hD000);
        // FIFO now holds 3,0,1,2
        tick; req_rd = '0; mem_ack = 1'b1; mem_rdata = 16'hD001; #1;
        chk("cred_outst4", 32'(outst_cnt), 4);
        chk("cred_raddr", 32'(mem_raddr), 32'h12);
        tick; mem_rdata = 16'hD002; #1;
        chk("drain_rsp3", 32'(rsp_ack), 32'h8);
        chk("drain_rdata3", 32'(rsp_rdata), 32'hD001);

        // Grant and ack together at outst_cnt=2
        tick; req_rd = 4'b1000; req_qid = {8'h33, 8'h12, 8'h11, 8'h10}; mem_rdata = 16'hD003; #1;
        chk("sim_outst_before", 32'(outst_cnt), 2);
        chk("sim_gnt", 32'(req_gnt), 32'h8);
        chk("drain_rsp0", 32'(rsp_ack), 32'h1);
        tick; req_rd = '0; mem_rdata = 16'hD004; #1;
        chk("sim_outst_after", 32'(outst_cnt), 2);
        chk("sim_raddr", 32'(mem_raddr), 32'h33);
        chk("sim_rsp1", 32'(rsp_ack), 32'h2);
        chk("sim_rdata1", 32'(rsp_rdata), 32'hD003);
        tick; mem_rdata = 16'hD005; #1;
        chk("sim_rsp2", 32'(rsp_ack), 32'h4);
        chk("sim_rdata2", 32'(rsp_rdata), 32'hD004);
        chk("sim_outst1", 32'(outst_cnt), 1);
        tick; mem_ack = 1'b0; #1;
        chk("sim_rsp3", 32'(rsp_ack), 32'h8);
        chk("sim_rdata3", 32'(rsp_rdata), 32'hD005);
        chk("sim_outst0", 32'(outst_cnt), 0);

        // Orphan ack
        tick; mem_ack = 1'b1; mem_rdata = 16'hEEEE; #1;
        chk("orph_err_before", 32'(err_orphan_ack), 0);
        tick; mem_ack = 1'b0; #1;
        chk("orph_err", 32'(err_orphan_ack), 1);
        chk("orph_rsp", 32'(rsp_ack), 0);
        chk("orph_outst", 32'(outst_cnt), 0);
        chk("orph_rdata_hold", 32'(rsp_rdata), 32'hD005);
        tick; #1;
        chk("orph_err_sticky", 32'(err_orphan_ack), 1);

        // Reset mid-flight
        tick; rst = 1'b1; tick; rst = 1'b0; #1;
        chk("rst2_err_clear", 32'(err_orphan_ack), 0);
        req_qid = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 3; k++) begin
            tick; req_rd = 4'b0111; #1;
            chk($sformatf("mid_gnt%0d", k), 32'(req_gnt), 32'(1) << k);
        end
        tick; req_rd = '0; #1;
        chk("mid_outst3", 32'(outst_cnt), 3);
        #2 rst = 1'b1; req_rd = 4'b0001;
        #1;
        chk("mid_rst_gnt", 32'(req_gnt), 0);
        chk("mid_rst_rd", 32'(mem_rd), 0);
        chk("mid_rst_raddr", 32'(mem_raddr), 0);
        chk("mid_rst_outst", 32'(outst_cnt), 0);
        chk("mid_rst_rsp", 32'(rsp_ack), 0);
        chk("mid_rst_rdata", 32'(rsp_rdata), 0);
        tick; tick;
        rst = 1'b0; req_rd = '0; mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick; mem_ack = 1'b0; req_rd = 4'b0001; #1;
        chk("stale_err", 32'(err_orphan_ack), 1);
        chk("stale_rsp", 32'(rsp_ack), 0);
        chk("stale_outst", 32'(outst_cnt), 0);
        chk("post_rst_gnt", 32'(req_gnt), 32'h1);
        tick; req_rd = '0; #1;
        chk("post_rst_rd", 32'(mem_rd), 1);
        chk("post_rst_raddr", 32'(mem_raddr), 32'h10);
        chk("post_rst_outst", 32'(outst_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
